sram_bus_ctrl: RTL and testbench

// - Initiator side of the 2MiB x16 SRAM pin interface (CEn/OEn/WEn/UBn/LBn, 20-bit word addr).
// - Converts 68000-style async bus cycles (AS/UDS/LDS/RW) into registered SRAM strobe sequences.
// - Returns DTACK to the CPU.
// - Sits between the CPU bus decode and the SRAM. All I/O is in the clk domain.

---
 rtl/sram_bus_pkg.sv | 33 +++
 rtl/sram_bus_ctrl_if.sv | 36 +++
 rtl/sram_bus_ctrl.sv | 118 +++++++++++
 tb/tb_sram_bus_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared types and constants for the SRAM bus controller
package sram_bus_pkg;

  localparam int SRAM_AW = 20;
  localparam int CNT_W   = 4;

  localparam logic [15:0] LANE_UPPER = 16'hFF00;
  localparam logic [15:0] LANE_LOWER = 16'h00FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ACK,
    ST_MISS
  } state_t;

  typedef struct packed {
    logic cen;
    logic oen;
    logic wen;
    logic ubn;
    logic lbn;
  } strobes_t;

  localparam strobes_t STROBES_OFF = '{cen: 1'b1, oen: 1'b1, wen: 1'b1, ubn: 1'b1, lbn: 1'b1};

  // Bits of the data word belonging to the enabled byte lanes (active-low enables).
  function automatic logic [15:0] lane_mask(input logic ubn, input logic lbn);
    lane_mask = (ubn ? 16'h0000 : LANE_UPPER) | (lbn ? 16'h0000 : LANE_LOWER);
  endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// rtl/sram_bus_ctrl_if.sv - 68000-style CPU bus plus SRAM pin bundle
interface sram_bus_ctrl_if;
  import sram_bus_pkg::*;

  logic [23:1]        cpu_addr;
  logic               cpu_as_n;
  logic               cpu_uds_n;
  logic               cpu_lds_n;
  logic               cpu_rw;
  logic [15:0]        cpu_wdata;
  logic [15:0]        cpu_rdata;
  logic               cpu_dtack_n;

  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic               sram_cen;
  logic               sram_oen;
  logic               sram_wen;
  logic               sram_ubn;
  logic               sram_lbn;

  // master: CPU plus SRAM device side; slave: the controller.
  modport master (
    output cpu_addr, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_wdata, sram_rdata,
    input  cpu_rdata, cpu_dtack_n, sram_addr, sram_wdata,
    input  sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn
  );

  modport slave (
    input  cpu_addr, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_wdata, sram_rdata,
    output cpu_rdata, cpu_dtack_n, sram_addr, sram_wdata,
    output sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn
  );

endinterface

// File: rtl/sram_bus_ctrl.sv
// rtl/sram_bus_ctrl.sv - converts async 68000 bus cycles into registered SRAM strobe sequences
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  sram_bus_ctrl_if.slave  bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  strobes_t           r_strb;
  logic               r_rw;
  logic [SRAM_AW-1:0] r_addr;
  logic [15:0]        r_wdata;
  logic [15:0]        r_rdata;
  logic               r_dtack_n;

  logic               w_start;
  logic               w_hit;
  logic [15:0]        w_lane_mask;

  assign w_start     = !bus.cpu_as_n && (!bus.cpu_uds_n || !bus.cpu_lds_n);
  assign w_hit       = (bus.cpu_addr[23:21] == BASE_ADDR[23:21]);
  assign w_lane_mask = lane_mask(r_strb.ubn, r_strb.lbn);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_strb    <= STROBES_OFF;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_dtack_n <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_dtack_n <= 1'b1;
          if (w_start) begin
            if (w_hit) begin
              // Lanes, direction and data are frozen here for the whole cycle.
              r_addr  <= bus.cpu_addr[20:1];
              r_rw    <= bus.cpu_rw;
              r_wdata <= bus.cpu_wdata;
              r_strb  <= '{cen: 1'b0, oen: 1'b1, wen: 1'b1,
                           ubn: bus.cpu_uds_n, lbn: bus.cpu_lds_n};
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_MISS;
            end
          end
        end

        ST_SETUP: begin
          if (bus.cpu_as_n) begin
            r_strb  <= STROBES_OFF;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            if (r_rw) r_strb.oen <= 1'b0;
            else      r_strb.wen <= 1'b0;
            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
            r_state <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (bus.cpu_as_n) begin
            r_strb  <= STROBES_OFF;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == '0) begin
            // Disabled lanes float on the SRAM side, so they are zeroed rather than passed on.
            if (r_rw) r_rdata <= bus.sram_rdata & w_lane_mask;
            r_strb    <= STROBES_OFF;
            r_dtack_n <= 1'b0;
            r_state   <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_ACK: begin
          if (bus.cpu_as_n) begin
            r_dtack_n <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        ST_MISS: begin
          if (bus.cpu_as_n) r_state <= ST_IDLE;
        end

        default: begin
          r_strb    <= STROBES_OFF;
          r_dtack_n <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata   = r_rdata;
  assign bus.cpu_dtack_n = r_dtack_n;
  assign bus.sram_addr   = r_addr;
  assign bus.sram_wdata  = r_wdata;
  assign bus.sram_cen    = r_strb.cen;
  assign bus.sram_oen    = r_strb.oen;
  assign bus.sram_wen    = r_strb.wen;
  assign bus.sram_ubn    = r_strb.ubn;
  assign bus.sram_lbn    = r_strb.lbn;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb/tb_sram_bus_ctrl.sv - scoreboard bench for sram_bus_ctrl with WAIT_CYCLES=2 and =5 instances
module tb_sram_bus_ctrl;
  import sram_bus_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        sel   = 1'b0;
  logic [23:1] cpu_addr = '0;
  logic        as_n  = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        rw    = 1'b1;
  logic [15:0] wdata = '0;

  sram_bus_ctrl_if bus_a ();
  sram_bus_ctrl_if bus_b ();

  assign bus_a.cpu_addr  = cpu_addr;
  assign bus_a.cpu_as_n  = sel ? 1'b1 : as_n;
  assign bus_a.cpu_uds_n = uds_n;
  assign bus_a.cpu_lds_n = lds_n;
  assign bus_a.cpu_rw    = rw;
  assign bus_a.cpu_wdata = wdata;
  assign bus_b.cpu_addr  = cpu_addr;
  assign bus_b.cpu_as_n  = sel ? as_n : 1'b1;
  assign bus_b.cpu_uds_n = uds_n;
  assign bus_b.cpu_lds_n = lds_n;
  assign bus_b.cpu_rw    = rw;
  assign bus_b.cpu_wdata = wdata;

  sram_bus_ctrl #(.BASE_ADDR(24'h000000), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  sram_bus_ctrl #(.BASE_ADDR(24'h000000), .WAIT_CYCLES(5)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  // SRAM models; disabled lanes return junk so the controller's lane masking is exercised.
  logic [15:0] mem_a [int];
  logic [15:0] mem_b [int];
  logic [15:0] ram_a_q = 16'h0;
  logic [15:0] ram_b_q = 16'h0;
  logic [15:0] cur_a, cur_b;
  assign bus_a.sram_rdata = ram_a_q;
  assign bus_b.sram_rdata = ram_b_q;

  always @(posedge clk) begin
    cur_a = mem_a.exists(int'(bus_a.sram_addr)) ? mem_a[int'(bus_a.sram_addr)] : 16'h0;
    if (!bus_a.sram_cen && !bus_a.sram_wen)
      mem_a[int'(bus_a.sram_addr)] = {bus_a.sram_ubn ? cur_a[15:8] : bus_a.sram_wdata[15:8],
                                      bus_a.sram_lbn ? cur_a[7:0]  : bus_a.sram_wdata[7:0]};
    if (!bus_a.sram_cen && !bus_a.sram_oen)
      ram_a_q <= {bus_a.sram_ubn ? 8'hEE : cur_a[15:8], bus_a.sram_lbn ? 8'hEE : cur_a[7:0]};
  end

  always @(posedge clk) begin
    cur_b = mem_b.exists(int'(bus_b.sram_addr)) ? mem_b[int'(bus_b.sram_addr)] : 16'h0;
    if (!bus_b.sram_cen && !bus_b.sram_wen)
      mem_b[int'(bus_b.sram_addr)] = {bus_b.sram_ubn ? cur_b[15:8] : bus_b.sram_wdata[15:8],
                                      bus_b.sram_lbn ? cur_b[7:0]  : bus_b.sram_wdata[7:0]};
    if (!bus_b.sram_cen && !bus_b.sram_oen)
      ram_b_q <= {bus_b.sram_ubn ? 8'hEE : cur_b[15:8], bus_b.sram_lbn ? 8'hEE : cur_b[7:0]};
  end

  logic        m_dtack_n;
  logic [15:0] m_rdata, m_wdata;
  logic [19:0] m_addr;
  logic [4:0]  m_strb;
  assign m_dtack_n = sel ? bus_b.cpu_dtack_n : bus_a.cpu_dtack_n;
  assign m_rdata   = sel ? bus_b.cpu_rdata   : bus_a.cpu_rdata;
  assign m_wdata   = sel ? bus_b.sram_wdata  : bus_a.sram_wdata;
  assign m_addr    = sel ? bus_b.sram_addr   : bus_a.sram_addr;
  assign m_strb    = sel ? {bus_b.sram_cen, bus_b.sram_oen, bus_b.sram_wen, bus_b.sram_ubn, bus_b.sram_lbn}
                         : {bus_a.sram_cen, bus_a.sram_oen, bus_a.sram_wen, bus_a.sram_ubn, bus_a.sram_lbn};

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic [19:0] addr;
    int          e0;
    int          lat;
    int          wen;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   wen_cnt = 0;
  logic prev_dtack = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DTACK falling edge must match the oldest expected access.
  always @(negedge clk) begin
    if (as_n) wen_cnt = 0;
    else if (!m_strb[2]) wen_cnt++;
    if (prev_dtack && !m_dtack_n) begin
      if (q.size() == 0) begin
        chk("unexpected_dtack", {31'b0, m_dtack_n}, 32'd1);
      end else begin
        mon_e = q.pop_front();
        chk("dtack_latency", cyc, mon_e.e0 + mon_e.lat);
        chk("wen_low_cycles", wen_cnt, mon_e.wen);
        chk("sram_addr", {12'b0, m_addr}, {12'b0, mon_e.addr});
        if (mon_e.rd) chk("cpu_rdata", {16'b0, m_rdata}, {16'b0, mon_e.data});
        else          chk("sram_wdata_hold", {16'b0, m_wdata}, {16'b0, mon_e.data});
      end
    end
    prev_dtack = m_dtack_n;
  end

  function automatic int wait_cycles();
    return sel ? 5 : 2;
  endfunction

  task automatic drive(input logic r, input logic [23:0] a, input logic u, input logic l,
                       input logic [15:0] d);
    @(posedge clk); #2;
    cpu_addr = a[23:1];
    rw       = r;
    uds_n    = u;
    lds_n    = l;
    if (!r) wdata = d;
    as_n     = 1'b0;
  endtask

  task automatic release_bus();
    @(posedge clk); #2;
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_dtack(input string name);
    int n = 0;
    while (m_dtack_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_dtack_n) chk({name, "_timeout"}, {31'b0, m_dtack_n}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_strobes_dtack"}, {26'b0, m_strb, m_dtack_n}, 32'h3F);
    chk({tag, "_cpu_rdata"}, {16'b0, m_rdata}, 32'h0);
    chk({tag, "_sram_addr"}, {12'b0, m_addr}, 32'h0);
    chk({tag, "_sram_wdata"}, {16'b0, m_wdata}, 32'h0);
  endtask

  // d is write data for writes and the expected read data for reads.
  task automatic do_access(input logic r, input logic [23:0] a, input logic u, input logic l,
                           input logic [15:0] d, input int hold);
    exp_t e;
    int   bad = 0;
    drive(r, a, u, l, d);
    e.rd   = r;
    e.data = d;
    e.addr = a[20:1];
    e.e0   = cyc + 1;
    e.lat  = 1 + wait_cycles();
    e.wen  = r ? 0 : wait_cycles();
    q.push_back(e);
    wait_dtack("access");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (m_dtack_n !== 1'b0 || m_strb !== 5'h1F) bad++;
    end
    if (hold > 0) chk("ack_hold_single_access", bad, 0);
    release_bus();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #2 rstn = 1'b1;

    do_access(1'b0, 24'h000010, 1'b0, 1'b0, 16'h1234, 0);
    do_access(1'b1, 24'h000010, 1'b0, 1'b0, 16'h1234, 0);
    do_access(1'b0, 24'h000010, 1'b0, 1'b1, 16'hABCD, 0);
    do_access(1'b1, 24'h000010, 1'b0, 1'b0, 16'hAB34, 0);
    do_access(1'b1, 24'h000010, 1'b1, 1'b0, 16'h0034, 0);
    do_access(1'b1, 24'h000010, 1'b0, 1'b1, 16'hAB00, 0);

    // Outside the 2MiB window: nothing may move.
    bad = 0;
    drive(1'b0, 24'h200000, 1'b0, 1'b0, 16'h9999);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_strb !== 5'h1F || m_dtack_n !== 1'b1) bad++;
    end
    chk("miss_no_strobes", bad, 0);
    release_bus();
    do_access(1'b1, 24'h000010, 1'b0, 1'b0, 16'hAB34, 0);

    // Abort: AS released while in ACCESS.
    drive(1'b0, 24'h000020, 1'b0, 1'b0, 16'h5555);
    @(posedge clk);
    @(posedge clk); #2 as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_strobes_dtack", {26'b0, m_strb, m_dtack_n}, 32'h3F);
    release_bus();
    do_access(1'b1, 24'h000010, 1'b0, 1'b0, 16'hAB34, 0);

    // Reset while in ACK, AS still low.
    begin
      exp_t e;
      drive(1'b1, 24'h000010, 1'b0, 1'b0, 16'h0);
      e.rd = 1'b1; e.data = 16'hAB34; e.addr = 20'h8; e.e0 = cyc + 1; e.lat = 3; e.wen = 0;
      q.push_back(e);
      wait_dtack("rst_ack");
      @(posedge clk); #2 rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("rst_in_ack");
      @(posedge clk); #2;
      rstn = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (2) @(posedge clk);
    end

    // Reset while in ACCESS, AS still low.
    drive(1'b0, 24'h000030, 1'b0, 1'b0, 16'h7777);
    @(posedge clk);
    @(posedge clk); #2 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_in_access");
    @(posedge clk); #2;
    rstn = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (2) @(posedge clk);
    do_access(1'b1, 24'h000010, 1'b0, 1'b0, 16'hAB34, 0);

    // WAIT_CYCLES=5 instance.
    @(posedge clk); #2 sel = 1'b1;
    repeat (2) @(posedge clk);
    do_access(1'b0, 24'h000040, 1'b0, 1'b0, 16'hBEEF, 0);
    do_access(1'b1, 24'h000040, 1'b0, 1'b0, 16'hBEEF, 10);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
